// File: rtl/reg_read_stage.sv
// Operand-read stage for the 4-entry register file: forwards same-cycle writes,
// registers rs/rt operands behind a valid/ready output, refreshes held operands.
module reg_read_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        rs,
  input  logic [1:0]        rt,
  input  logic [DATA_W-1:0] reg0,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [DATA_W-1:0] reg3,
  input  logic              reg0_en,
  input  logic              reg1_en,
  input  logic              reg2_en,
  input  logic              reg3_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        rs_q,
  output logic [1:0]        rt_q,
  output logic              wr_err
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [1:0]        r_rs_q;
  logic [1:0]        r_rt_q;
  logic              r_wr_err;

  logic [3:0]        w_en;
  logic [DATA_W-1:0] w_sel [4];
  logic              w_multi_en;
  logic              w_capture;

  assign w_en = {reg3_en, reg2_en, reg1_en, reg0_en};

  // Write-through: an enabled register reads as this cycle's write data.
  always_comb begin
    w_sel[0] = reg0_en ? wr_data : reg0;
    w_sel[1] = reg1_en ? wr_data : reg1;
    w_sel[2] = reg2_en ? wr_data : reg2;
    w_sel[3] = reg3_en ? wr_data : reg3;
  end

  assign w_multi_en = (reg0_en & (reg1_en | reg2_en | reg3_en)) |
                      (reg1_en & (reg2_en | reg3_en)) |
                      (reg2_en & reg3_en);

  assign in_ready  = ~r_out_valid | out_ready;
  assign w_capture = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rs_q      <= '0;
      r_rt_q      <= '0;
      r_wr_err    <= 1'b0;
    end else begin
      if (w_multi_en) r_wr_err <= 1'b1;

      // Flush only drops valid; operand registers keep their contents.
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_capture) begin
        r_op_a      <= w_sel[rs];
        r_op_b      <= w_sel[rt];
        r_rs_q      <= rs;
        r_rt_q      <= rt;
        r_out_valid <= 1'b1;
      end else if (r_out_valid & out_ready) begin
        r_out_valid <= 1'b0;
      end else if (r_out_valid) begin
        if (w_en[r_rs_q]) r_op_a <= wr_data;
        if (w_en[r_rt_q]) r_op_b <= wr_data;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign rs_q      = r_rs_q;
  assign rt_q      = r_rt_q;
  assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_reg_read_stage.sv
// Self-checking bench for reg_read_stage: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the stage.
module tb_reg_read_stage;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        rs, rt;
  logic [DATA_W-1:0] regs [4];
  logic [3:0]        en;
  logic [DATA_W-1:0] wr_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] op_a, op_b;
  logic [1:0]        rs_q, rt_q;
  logic              wr_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic              m_valid;
  logic [DATA_W-1:0] m_a, m_b;
  logic [1:0]        m_rsq, m_rtq;
  logic              m_err;

  always #5 clk = ~clk;

  reg_read_stage #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt),
    .reg0(regs[0]), .reg1(regs[1]), .reg2(regs[2]), .reg3(regs[3]),
    .reg0_en(en[0]), .reg1_en(en[1]), .reg2_en(en[2]), .reg3_en(en[3]),
    .wr_data(wr_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .rs_q(rs_q), .rt_q(rt_q),
    .wr_err(wr_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] read_reg(input logic [1:0] idx);
    return en[idx] ? wr_data : regs[idx];
  endfunction

  // Model one rising edge from the currently driven inputs.
  task automatic model_edge();
    int unsigned n_en;
    logic        accept;
    n_en = 0;
    for (int unsigned i = 0; i < 4; i++) if (en[i]) n_en++;
    if (rst) begin
      m_valid = 0; m_a = '0; m_b = '0; m_rsq = '0; m_rtq = '0; m_err = 0;
      return;
    end
    if (n_en >= 2) m_err = 1;
    accept = in_valid && (!m_valid || out_ready);
    if (flush) begin
      m_valid = 0;
    end else if (accept) begin
      m_a = read_reg(rs); m_b = read_reg(rt);
      m_rsq = rs; m_rtq = rt; m_valid = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end else if (m_valid) begin
      if (en[m_rsq]) m_a = wr_data;
      if (en[m_rtq]) m_b = wr_data;
    end
  endtask

  task automatic step();
    #1;
    check_eq("in_ready", in_ready, (!m_valid || out_ready));
    @(posedge clk);
    model_edge();
    #1;
    check_eq("out_valid", out_valid, m_valid);
    check_eq("op_a", op_a, m_a);
    check_eq("op_b", op_b, m_b);
    check_eq("rs_q", rs_q, m_rsq);
    check_eq("rt_q", rt_q, m_rtq);
    check_eq("wr_err", wr_err, m_err);
  endtask

  task automatic idle_inputs();
    rst = 0; in_valid = 0; flush = 0; out_ready = 1; en = '0; wr_data = '0;
  endtask

  initial begin
    m_valid = 0; m_a = '0; m_b = '0; m_rsq = '0; m_rtq = '0; m_err = 0;
    idle_inputs();
    rs = 0; rt = 0;
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
    @(posedge clk); #1;

    // Reset
    rst = 1; step();
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_op_a", op_a, 0);
    check_eq("reset_in_ready", in_ready, 1);
    rst = 0;

    // Basic read
    in_valid = 1; rs = 2; rt = 1; step();
    check_eq("basic_op_a", op_a, 8'h33);
    check_eq("basic_op_b", op_b, 8'h22);

    // Same-cycle forward
    rs = 3; rt = 3; en = 4'b1000; wr_data = 8'hA5; step();
    check_eq("fwd_op_a", op_a, 8'hA5);
    check_eq("fwd_op_b", op_b, 8'hA5);
    en = '0;

    // Stall refresh
    rs = 1; rt = 2; step();
    in_valid = 0; out_ready = 0;
    for (int unsigned c = 0; c < 3; c++) begin
      en = (c == 1) ? 4'b0100 : 4'b0000;
      wr_data = (c == 1) ? 8'h5C : 8'h00;
      step();
      check_eq("stall_in_ready", in_ready, 0);
      check_eq("stall_valid", out_valid, 1);
      if (c >= 1) check_eq("stall_op_b", op_b, 8'h5C);
      check_eq("stall_op_a", op_a, 8'h22);
    end
    en = '0;

    // Back-to-back, first op drains the stalled one in the same cycle
    out_ready = 1; in_valid = 1;
    for (int unsigned c = 0; c < 4; c++) begin
      rs = 2'(c); rt = 2'(3 - c);
      step();
      check_eq("b2b_valid", out_valid, 1);
      check_eq("b2b_op_a", op_a, regs[c]);
    end

    // Flush with a concurrent incoming op
    rs = 0; rt = 0; step();
    in_valid = 0; out_ready = 0; step();
    in_valid = 1; flush = 1; rs = 3; rt = 3; step();
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_rs_q", rs_q, 0);
    flush = 0; rs = 1; rt = 2; step();
    check_eq("post_flush_valid", out_valid, 1);
    check_eq("post_flush_op_a", op_a, 8'h22);

    // Multi-enable then reset during a stall
    in_valid = 0; en = 4'b0011; wr_data = 8'h77; step();
    check_eq("multi_err", wr_err, 1);
    en = '0; step(); step();
    check_eq("err_sticky", wr_err, 1);
    rst = 1; step();
    check_eq("rst_err", wr_err, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_op_b", op_b, 0);
    rst = 0; out_ready = 1;

    // Random traffic
    for (int unsigned c = 0; c < 600; c++) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] = DATA_W'($urandom);
      rs = 2'($urandom); rt = 2'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 60) == 0);
      wr_data   = DATA_W'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: en = '0;
        9:          en = 4'($urandom);
        default:    en = 4'b0001 << $urandom_range(0, 3);
      endcase
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Operand-read pipeline stage for the sCPU's 4-entry register file, on the read side of the write-enable decoder. Takes source register indices `rs`/`rt` with a valid/ready handshake and selects their values from the four register outputs. It forwards same-cycle write data from the one-hot write enables into the operands, and presents them one cycle later through a registered valid/ready output. Operands held during back-pressure stay coherent with later writes. A branch flush kills the held operation.

## Interface
- `DATA_W`, default 8: width of register values and write data.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream presents `rs`/`rt`.
- `in_ready` out 1: stage can accept this cycle.
- `rs` in 2: first source register index.
- `rt` in 2: second source register index.
- `reg0`…`reg3` in DATA_W each: current register file contents.
- `reg0_en`…`reg3_en` in 1 each: write enables from the write-side decoder, active this cycle.
- `wr_data` in DATA_W: data written to the enabled register this cycle.
- `flush` in 1: taken-branch kill; drops held and incoming operation.
- `out_valid` out 1: `op_a`/`op_b` valid.
- `out_ready` in 1: downstream accepts.
- `op_a` out DATA_W: value of register `rs`.
- `op_b` out DATA_W: value of register `rt`.
- `rs_q`, `rt_q` out 2 each: indices of the held operation.
- `wr_err` out 1: sticky; set when more than one `regN_en` is high in a cycle.

## Operation
- State:
  - `out_valid`
  - `op_a`, `op_b`
  - `rs_q`, `rt_q`
  - `wr_err`
- `in_ready = ~out_valid | out_ready`. This is combinational and does not depend on `in_valid`.
- Operand select, per index `i`: `sel(i) = regI_en ? wr_data : regI`. This is write-through forwarding: a same-cycle write is visible.
- **Capture**, when `in_valid & in_ready & ~flush`:
  - `op_a <= sel(rs)`, `op_b <= sel(rt)`.
  - `rs_q <= rs`, `rt_q <= rt`.
  - `out_valid <= 1`.
- **Drain**, when `out_valid & out_ready` with no capture in the same cycle: `out_valid <= 0`. `op_a`, `op_b`, `rs_q`, `rt_q` keep their values.
- **Hold refresh**, when `out_valid & ~out_ready & ~flush`:
  - If `reg[rs_q]_en`, then `op_a <= wr_data`.
  - If `reg[rt_q]_en`, then `op_b <= wr_data`.
  - Both operands update when `rs_q == rt_q`.
- **Flush** has the highest priority after reset:
  - `out_valid <= 0`.
  - An incoming `in_valid` in the same cycle is discarded.
  - The operand registers are not cleared.
- **Write-error flag**:
  - `wr_err <= 1` whenever two or more enables are high.
  - It clears only on `rst`.
  - Forwarding still applies per register; each enabled register gets `wr_data`.
- Flush/reset only clear valid; data registers keep their values. Downstream must qualify the operands with `out_valid`.

## Timing
- Latency: 1 cycle from accepted `in_valid` to `out_valid`.
- Throughput: 1 op/cycle while `out_ready` stays high. Simultaneous drain and capture keeps `out_valid = 1` with the new operands.
- Reset values: `out_valid=0`, `op_a=0`, `op_b=0`, `rs_q=0`, `rt_q=0`, `wr_err=0`, so `in_ready=1`.
- Reset mid-operation: the held op is lost. The next cycle accepts new input.
- Handshake rules:
  - `out_valid` never drops without `out_ready` or `flush`.
  - `op_a`/`op_b` change while stalled only through hold refresh.
- Enables and `wr_data` are sampled in the same cycle as capture or refresh; the stage adds no extra write-side delay.
- `flush` with `out_valid=0` and `in_valid=0` has no effect.

## Test plan
- **Basic read.** Reset, then set `reg0..3 = 8'h11,22,33,44`, `rs=2`, `rt=1`, `in_valid=1`, `out_ready=1`, no enables. Required: next cycle `out_valid=1`, `op_a=8'h33`, `op_b=8'h22`.
- **Same-cycle forward.** `rs=3`, `rt=3`, `reg3_en=1`, `wr_data=8'hA5`, `reg3=8'h44`. Required: `op_a=op_b=8'hA5`.
- **Stall refresh.** Capture `rs=1`, `rt=2`, then hold `out_ready=0` for 3 cycles. Pulse `reg2_en`, `wr_data=8'h5C` in cycle 2. Required:
  - `op_b=8'h5C` from the next cycle.
  - `op_a` unchanged.
  - `out_valid` stays 1.
  - `in_ready=0` throughout the stall.
- **Back-to-back.** 4 consecutive ops with `out_ready=1`. Required: `out_valid` stays 1 for 4 cycles, `in_ready` stays 1, and the results appear in order.
- **Flush.** Stall a valid op, then assert `flush` together with a new `in_valid`. Required: next cycle `out_valid=0`; the new op does not appear. The next clean `in_valid` is captured normally.
- **Multi-enable and reset.** Assert `reg0_en` and `reg1_en` together. Required: `wr_err=1`, and it stays set until `rst`. Assert `rst` during a stall. Required: all outputs return to 0 on the next edge.
